// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_pkg
// Desc   : Shared state encoding, geometry helpers and address-field extractors
//          for the direct-mapped data-cache controller.
// Rev    : 1.0  initial release
// ============================================================================
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } cache_state_t;

  function automatic int unsigned index_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned aw, input int unsigned sets);
    return aw - 2 - index_w(sets);
  endfunction

  // Extractors work on a zero-extended 64-bit address; callers size-cast the result.
  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int unsigned sets);
    return (addr >> 2) & 64'(sets - 1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int unsigned sets);
    return addr >> (2 + index_w(sets));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_tag_store.sv
`default_nettype none
// ============================================================================
// Module : cache_tag_store
// Desc   : Valid bits and tag array; synchronous write/clear, combinational hit.
// Rev    : 1.0  initial release
// ============================================================================
module cache_tag_store #(
  parameter int unsigned SETS    = 64,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit
);

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  valid_d;
  logic [TAG_W-1:0] tag_mem [SETS];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  assign hit = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cache_ctrl
// Desc   : Direct-mapped, write-through, no-write-allocate data-cache controller.
//          Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
// Rev    : 1.0  initial release
// ============================================================================
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WD   = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned SETS = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [WD-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          hit,
  output logic [WD-1:0] cache_word,
  output logic [WD-1:0] mem_word,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [WD-1:0] mem_wdata,
  input  logic [WD-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt,
`endif
  input  logic          mem_ack
);

  localparam int unsigned INDEX_W = index_w(SETS);
  localparam int unsigned TAG_W   = tag_w(AW, SETS);

  cache_state_t state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [WD-1:0] mem_wdata_q, mem_wdata_d;
  logic [WD-1:0] mem_word_q, mem_word_d;
  logic          hit_entry_q, hit_entry_d;

  logic [WD-1:0]      data_mem [SETS];
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               lookup_hit;
  logic               tag_wr;
  logic               data_wr;
  logic [WD-1:0]      data_wdata;

  assign index = INDEX_W'(addr_index(64'(cpu_addr), SETS));
  assign tag   = TAG_W'(addr_tag(64'(cpu_addr), SETS));

  cache_tag_store #(
    .SETS    (SETS),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (tag_wr),
    .wr_index (index),
    .wr_tag   (tag),
    .rd_index (index),
    .rd_tag   (tag),
    .hit      (lookup_hit)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_word_d  = mem_word_q;
    hit_entry_d = hit_entry_q;
    cpu_stall   = 1'b0;
    tag_wr      = 1'b0;
    data_wr     = 1'b0;
    data_wdata  = cpu_wdata;

    case (state_q)
      IDLE: begin
        if (cpu_req && (cpu_we || !lookup_hit)) begin
          cpu_stall   = 1'b1;
          state_d     = cpu_we ? WRITE : REFILL;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = {cpu_addr[AW-1:2], 2'b00};
          mem_wdata_d = cpu_wdata;
          hit_entry_d = lookup_hit;
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        if (mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          mem_word_d = mem_rdata;
          tag_wr     = 1'b1;
          data_wr    = 1'b1;
          data_wdata = mem_rdata;
        end
      end
      WRITE: begin
        cpu_stall = 1'b1;
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // No-write-allocate: only a line that was resident at entry is updated.
          data_wr   = hit_entry_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rst) begin
      cpu_stall = 1'b0;
      tag_wr    = 1'b0;
      data_wr   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_word_q  <= '0;
      hit_entry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_word_q  <= mem_word_d;
      hit_entry_q <= hit_entry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_wr) begin
      data_mem[index] <= data_wdata;
    end
  end

  assign hit        = !rst && lookup_hit;
  assign cache_word = data_mem[index];
  assign mem_word   = mem_word_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Load hits retire from IDLE; misses counted on entry to REFILL/WRITE.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && cpu_req) begin
      if (!cpu_we && lookup_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (!lookup_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// Self-checking bench for cache_ctrl: transaction-level cache/memory model,
// a per-cycle compare process, directed scenarios and a randomized phase.
module tb_cache_ctrl;

  localparam int WD   = 32;
  localparam int AW   = 32;
  localparam int SETS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        hit;
  logic [31:0] cache_word;
  logic [31:0] mem_word;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  cache_ctrl #(.WD(WD), .AW(AW), .SETS(SETS)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .hit        (hit),
    .cache_word (cache_word),
    .mem_word   (mem_word),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef CACHE_STATS_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: cache contents, backing memory, last refill word, stats.
  bit          m_valid [SETS];
  logic [23:0] m_tag   [SETS];
  logic [31:0] m_data  [SETS];
  logic [31:0] mem_m   [logic [31:0]];
  logic [31:0] m_last  = 32'd0;
  int          m_hits  = 0;
  int          m_misses = 0;

  bit          chk_en      = 1'b0;
  bit          chk_rstvals = 1'b0;
  logic        exp_stall   = 1'b0;
  logic        exp_mem_req = 1'b0;
  logic        exp_mem_we  = 1'b0;
  logic [31:0] exp_mem_addr  = 32'd0;
  logic [31:0] exp_mem_wdata = 32'd0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic logic [23:0] tag_of(input logic [31:0] a);
    return 24'(a / (4 * SETS));
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_last   = 32'd0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  int   c_i;
  logic c_hit;
  always @(negedge clk) begin
    if (chk_en) begin
      c_i   = idx_of(cpu_addr);
      c_hit = !rst && m_valid[c_i] && (m_tag[c_i] == tag_of(cpu_addr));
      cmp("hit", 32'(hit), 32'(c_hit));
      if (!rst && m_valid[c_i]) cmp("cache_word", cache_word, m_data[c_i]);
      cmp("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
      cmp("mem_req", 32'(mem_req), 32'(exp_mem_req));
      if (exp_mem_req) begin
        cmp("mem_we", 32'(mem_we), 32'(exp_mem_we));
        cmp("mem_addr", mem_addr, exp_mem_addr);
        if (exp_mem_we) cmp("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (chk_rstvals) begin
        cmp("rst_mem_we", 32'(mem_we), 32'd0);
        cmp("rst_mem_addr", mem_addr, 32'd0);
        cmp("rst_mem_wdata", mem_wdata, 32'd0);
      end
      cmp("mem_word", mem_word, m_last);
`ifdef CACHE_STATS_EN
      cmp("hit_cnt", hit_cnt, 32'(m_hits));
      cmp("miss_cnt", miss_cnt, 32'(m_misses));
`endif
    end
  end

  // One CPU access; lat = memory cycle (1-based) in which mem_ack is returned.
  // Enters and leaves 1 time unit after a rising edge.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input int lat, output int stalls, output logic hit_a,
                        output logic [31:0] cw_a, output logic [31:0] word_done,
                        output logic we_seen);
    bit          mh;
    int          i;
    logic [31:0] wa;
    i  = idx_of(a);
    mh = m_hit(a);
    wa = {a[31:2], 2'b00};
    stalls  = 0;
    we_seen = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    mem_ack = 1'b0; mem_rdata = $urandom;
    exp_stall   = we || !mh;
    exp_mem_req = 1'b0;
    #1;
    hit_a = hit; cw_a = cache_word; word_done = mem_word;
    if (cpu_stall === 1'b1) stalls++;
    @(posedge clk); #1;
    if (!we && mh) begin
      m_hits++;
      return;
    end
    if (!mh) m_misses++;
    exp_mem_req = 1'b1; exp_mem_we = we; exp_mem_addr = wa; exp_mem_wdata = wd;
    if (!we && !mem_m.exists(wa)) mem_m[wa] = $urandom;
    for (int k = 1; k <= lat; k++) begin
      mem_ack   = (k == lat);
      mem_rdata = $urandom;
      if (k == lat && !we) mem_rdata = mem_m[wa];
      #1;
      if (cpu_stall === 1'b1) stalls++;
      if (mem_we === 1'b1) we_seen = 1'b1;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (we) begin
      mem_m[wa] = wd;
      if (mh) m_data[i] = wd;
    end else begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(a);
      m_data[i]  = mem_m[wa];
      m_last     = mem_m[wa];
    end
    exp_mem_req = 1'b0;
    exp_stall   = 1'b0;
    #1;
    word_done = mem_word;
    if (cpu_stall === 1'b1) stalls++;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'(((($urandom % 4) * SETS) + ($urandom % 8)) * 4 + ($urandom % 4));
  endfunction

  task automatic idle_cycle();
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = rand_addr(); cpu_wdata = $urandom;
    mem_ack = (($urandom % 4) == 0); mem_rdata = $urandom;
    exp_stall = 1'b0; exp_mem_req = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  int          st;
  logic        ha;
  logic [31:0] cw;
  logic [31:0] wdn;
  logic        ws;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk_en = 1'b1; chk_rstvals = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    cmp("reset_mem_req", 32'(mem_req), 32'd0);
    cmp("reset_mem_word", mem_word, 32'd0);
    @(posedge clk); #1;
    chk_rstvals = 1'b0;

    // Cold miss then hit.
    mem_m[32'h100] = 32'hDEAD_BEEF;
    access(1'b0, 32'h100, 32'd0, 3, st, ha, cw, wdn, ws);
    cmp("cold_load_hit", 32'(ha), 32'd0);
    cmp("cold_load_stalls", 32'(st), 32'd4);
    cmp("cold_load_word", wdn, 32'hDEAD_BEEF);
    access(1'b0, 32'h100, 32'd0, 3, st, ha, cw, wdn, ws);
    cmp("rehit_hit", 32'(ha), 32'd1);
    cmp("rehit_stalls", 32'(st), 32'd0);
    cmp("rehit_word", cw, 32'hDEAD_BEEF);

    // Conflict on index 0.
    mem_m[32'h200] = 32'h0BAD_F00D;
    access(1'b0, 32'h200, 32'd0, 2, st, ha, cw, wdn, ws);
    cmp("conflict_hit", 32'(ha), 32'd0);
    cmp("conflict_word", wdn, 32'h0BAD_F00D);
    access(1'b0, 32'h100, 32'd0, 2, st, ha, cw, wdn, ws);
    cmp("reload_hit", 32'(ha), 32'd0);
    cmp("reload_word", wdn, 32'hDEAD_BEEF);

    // Store hit writes through and updates the line.
    access(1'b1, 32'h100, 32'h1234_5678, 2, st, ha, cw, wdn, ws);
    cmp("store_hit_hit", 32'(ha), 32'd1);
    cmp("store_hit_we", 32'(ws), 32'd1);
    access(1'b0, 32'h100, 32'd0, 2, st, ha, cw, wdn, ws);
    cmp("after_store_hit", 32'(ha), 32'd1);
    cmp("after_store_word", cw, 32'h1234_5678);

    // Store miss does not allocate.
    access(1'b1, 32'h300, 32'hCAFE_F00D, 1, st, ha, cw, wdn, ws);
    cmp("store_miss_hit", 32'(ha), 32'd0);
    access(1'b0, 32'h300, 32'd0, 2, st, ha, cw, wdn, ws);
    cmp("load_after_store_miss_hit", 32'(ha), 32'd0);
    cmp("load_after_store_miss_word", wdn, 32'hCAFE_F00D);

    // Ack in the first refill cycle.
    access(1'b0, 32'h2008, 32'd0, 1, st, ha, cw, wdn, ws);
    cmp("fast_ack_stalls", 32'(st), 32'd2);

    // Reset during the second refill cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1004; mem_ack = 1'b0;
    exp_stall = 1'b1; exp_mem_req = 1'b0;
    @(posedge clk); #1;
    m_misses++;
    exp_mem_req = 1'b1; exp_mem_we = 1'b0; exp_mem_addr = 32'h1004;
    @(posedge clk); #1;
    rst = 1'b1; exp_stall = 1'b0;
    @(posedge clk); #1;
    model_clear();
    rst = 1'b0; cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    exp_mem_req = 1'b0; chk_rstvals = 1'b1;
    #1;
    cmp("rst_mid_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0; chk_rstvals = 1'b0;
    cmp("late_ack_ignored", mem_word, 32'd0);
`ifdef CACHE_STATS_EN
    cmp("stats_rst_hits", hit_cnt, 32'd0);
    cmp("stats_rst_misses", miss_cnt, 32'd0);
`endif
    access(1'b0, 32'h100, 32'd0, 2, st, ha, cw, wdn, ws);
    cmp("post_rst_load_hit", 32'(ha), 32'd0);
    for (int n = 0; n < 3; n++) access(1'b0, 32'h100, 32'd0, 1, st, ha, cw, wdn, ws);
    access(1'b0, 32'h2008, 32'd0, 3, st, ha, cw, wdn, ws);
`ifdef CACHE_STATS_EN
    cmp("stats_hits", hit_cnt, 32'd3);
    cmp("stats_misses", miss_cnt, 32'd2);
`endif

    // Randomized traffic over a small address pool.
    for (int n = 0; n < 300; n++) begin
      int gaps;
      gaps = int'($urandom % 3);
      for (int g = 0; g < gaps; g++) idle_cycle();
      access(($urandom % 10) < 3, rand_addr(), $urandom, int'($urandom_range(1, 4)),
             st, ha, cw, wdn, ws);
    end
    idle_cycle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
